// File: rtl/brick_pkg.sv
// Shared types and constants for the brick manager.
package brick_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_OVER  = 2'd3
  } brick_state_t;

  localparam logic [9:0] TOP_ROW_MASK    = 10'h01F;
  localparam logic [9:0] BOTTOM_ROW_MASK = 10'h3E0;
  localparam int         LIVES_W         = 3;

endpackage

// File: rtl/brick_popcount.sv
// Combinational population count of a W-bit vector.
module brick_popcount #(
  parameter int W     = 10,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     vec,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/brick_manager.sv
// Brick/score/lives game-state keeper evaluated once per frame_tick.
// Optional macro BRICK_MANAGER_TWO_HIT_EN: top-row bricks need two hits.
//
// state    | meaning
// ST_PLAY  | brick, paddle and ball_lost events evaluated
// ST_HOLD  | brick hits ignored for LOCKOUT_FRAMES ticks after a bounce
// ST_CLEAR | all bricks gone, wait for new_game
// ST_OVER  | lives exhausted, wait for new_game
import brick_pkg::*;

module brick_manager #(
  parameter int NUM_BLOCKS     = 10,
  parameter int POINTS         = 10,
  parameter int LOCKOUT_FRAMES = 4,
  parameter int START_LIVES    = 3,
  parameter int SCORE_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic [NUM_BLOCKS-1:0] collide_block,
  input  logic                  collide_paddle,
  input  logic                  ball_lost,
  input  logic                  new_game,
  output logic [NUM_BLOCKS-1:0] block_alive,
  output logic [NUM_BLOCKS-1:0] block_cracked,
  output logic                  ball_dir_y,
  output logic [SCORE_W-1:0]    score,
  output logic [LIVES_W-1:0]    lives,
  output logic                  hit_pulse,
  output logic                  level_clear,
  output logic                  game_over
);

  localparam int POP_W = $clog2(NUM_BLOCKS + 1);
  localparam int CNT_W = (LOCKOUT_FRAMES < 2) ? 1 : $clog2(LOCKOUT_FRAMES + 1);
  localparam int SUM_W = SCORE_W + 16;

  brick_state_t          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_BLOCKS-1:0] alive_q, alive_d;
  logic                  dir_q, dir_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [LIVES_W-1:0]    lives_q, lives_d;
  logic                  hit_q, hit_d, clear_q, clear_d, over_q, over_d;

  logic [NUM_BLOCKS-1:0] hits, kill;
  logic [POP_W-1:0]      pop;
  logic [SUM_W-1:0]      sum;
  logic [SCORE_W-1:0]    score_sat;

  assign hits = collide_block & alive_q;

`ifdef BRICK_MANAGER_TWO_HIT_EN
  localparam logic [NUM_BLOCKS-1:0] TOP_MASK = NUM_BLOCKS'(TOP_ROW_MASK);
  logic [NUM_BLOCKS-1:0] cracked_q, cracked_d;
  // An uncracked top-row brick survives its first hit.
  assign kill          = hits & ~(TOP_MASK & ~cracked_q);
  assign block_cracked = cracked_q;
`else
  assign kill          = hits;
  assign block_cracked = '0;
`endif

  brick_popcount #(.W(NUM_BLOCKS), .CNT_W(POP_W)) u_popcount (
    .vec   (hits),
    .count (pop)
  );

  assign sum       = SUM_W'(score_q) + SUM_W'(POINTS) * SUM_W'(pop);
  assign score_sat = (|sum[SUM_W-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_PLAY;
      cnt_q     <= '0;
      alive_q   <= '1;
      dir_q     <= 1'b0;
      score_q   <= '0;
      lives_q   <= LIVES_W'(START_LIVES);
      hit_q     <= 1'b0;
      clear_q   <= 1'b0;
      over_q    <= 1'b0;
`ifdef BRICK_MANAGER_TWO_HIT_EN
      cracked_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alive_q   <= alive_d;
      dir_q     <= dir_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      hit_q     <= hit_d;
      clear_q   <= clear_d;
      over_q    <= over_d;
`ifdef BRICK_MANAGER_TWO_HIT_EN
      cracked_q <= cracked_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alive_d   = alive_q;
    dir_d     = dir_q;
    score_d   = score_q;
    lives_d   = lives_q;
    hit_d     = 1'b0;
`ifdef BRICK_MANAGER_TWO_HIT_EN
    cracked_d = cracked_q;
`endif
    if (new_game) begin
      state_d   = ST_PLAY;
      cnt_d     = '0;
      alive_d   = '1;
      dir_d     = 1'b0;
      score_d   = '0;
      lives_d   = LIVES_W'(START_LIVES);
`ifdef BRICK_MANAGER_TWO_HIT_EN
      cracked_d = '0;
`endif
    end else if (ball_lost && (state_q == ST_PLAY || state_q == ST_HOLD)) begin
      if (lives_q > LIVES_W'(1)) begin
        lives_d = lives_q - LIVES_W'(1);
        dir_d   = 1'b0;
        state_d = ST_PLAY;
        cnt_d   = '0;
      end else begin
        lives_d = '0;
        state_d = ST_OVER;
      end
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (frame_tick && (hits != '0)) begin
            alive_d = alive_q & ~kill;
`ifdef BRICK_MANAGER_TWO_HIT_EN
            cracked_d = cracked_q ^ (hits & TOP_MASK);
`endif
            score_d = score_sat;
            dir_d   = collide_paddle ? 1'b0 : ~dir_q;
            hit_d   = 1'b1;
            cnt_d   = CNT_W'(LOCKOUT_FRAMES);
            state_d = (alive_d == '0) ? ST_CLEAR : ST_HOLD;
          end else if (frame_tick && collide_paddle) begin
            dir_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (frame_tick && collide_paddle) dir_d = 1'b0;
          // A zero lockout leaves HOLD on the next cycle without waiting for a tick.
          if (cnt_q == '0) begin
            state_d = ST_PLAY;
          end else if (frame_tick) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_PLAY;
          end
        end
        default: ;
      endcase
    end
    clear_d = (state_d == ST_CLEAR);
    over_d  = (state_d == ST_OVER);
  end

  assign block_alive = alive_q;
  assign ball_dir_y  = dir_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign hit_pulse   = hit_q;
  assign level_clear = clear_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_brick_manager.sv
// Directed self-checking bench for brick_manager (default or two-hit build).
`timescale 1ns/1ps

module tb_brick_manager;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] collide_block = '0;
  logic       collide_paddle = 1'b0;
  logic       ball_lost = 1'b0;
  logic       new_game = 1'b0;
  logic [9:0] block_alive, block_cracked;
  logic       ball_dir_y;
  logic [15:0] score;
  logic [2:0] lives;
  logic       hit_pulse, level_clear, game_over;

  int n_checks = 0;
  int n_errors = 0;
  int hp_count;

  brick_manager dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .collide_block  (collide_block),
    .collide_paddle (collide_paddle),
    .ball_lost      (ball_lost),
    .new_game       (new_game),
    .block_alive    (block_alive),
    .block_cracked  (block_cracked),
    .ball_dir_y     (ball_dir_y),
    .score          (score),
    .lives          (lives),
    .hit_pulse      (hit_pulse),
    .level_clear    (level_clear),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic frame(input logic [9:0] blk, input logic pad);
    @(negedge clk);
    frame_tick     = 1'b1;
    collide_block  = blk;
    collide_paddle = pad;
    @(posedge clk);
    #1;
    frame_tick     = 1'b0;
    collide_block  = '0;
    collide_paddle = 1'b0;
  endtask

  task automatic pulse_lost();
    @(negedge clk);
    ball_lost = 1'b1;
    @(posedge clk);
    #1;
    ball_lost = 1'b0;
  endtask

  task automatic restart();
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    #1;
    new_game = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    idle(1);
    check_eq("rst_alive", block_alive, 10'h3FF);
    check_eq("rst_cracked", block_cracked, 10'h000);
    check_eq("rst_score", score, 0);
    check_eq("rst_lives", lives, 3);
    check_eq("rst_dir", ball_dir_y, 0);
    check_eq("rst_flags", {hit_pulse, level_clear, game_over}, 3'b000);

`ifdef BRICK_MANAGER_TWO_HIT_EN
    frame(10'h001, 1'b0);
    check_eq("th1_cracked", block_cracked, 10'h001);
    check_eq("th1_alive", block_alive, 10'h3FF);
    check_eq("th1_score", score, 10);
    check_eq("th1_dir", ball_dir_y, 1);
    check_eq("th1_pulse", hit_pulse, 1);
    repeat (5) frame(10'h000, 1'b0);
    frame(10'h001, 1'b0);
    check_eq("th2_cracked", block_cracked, 10'h000);
    check_eq("th2_alive", block_alive, 10'h3FE);
    check_eq("th2_score", score, 20);
    restart();
    repeat (1) frame(10'h020, 1'b0);
    check_eq("th_low_alive", block_alive, 10'h3DF);
    check_eq("th_low_cracked", block_cracked, 10'h000);
`else
    // single hit, one-cycle pulse
    frame(10'h004, 1'b0);
    check_eq("hit_alive", block_alive, 10'h3FB);
    check_eq("hit_score", score, 10);
    check_eq("hit_dir", ball_dir_y, 1);
    check_eq("hit_pulse_hi", hit_pulse, 1);
    idle(1);
    check_eq("hit_pulse_lo", hit_pulse, 0);

    // held overlap costs each brick once
    restart();
    hp_count = 0;
    for (int i = 0; i < 6; i++) begin
      frame(10'h021, 1'b0);
      hp_count += int'(hit_pulse);
    end
    check_eq("hold_alive", block_alive, 10'h3DE);
    check_eq("hold_score", score, 20);
    check_eq("hold_dir", ball_dir_y, 1);
    check_eq("hold_pulses", hp_count, 1);

    // lockout length: 4 ticks ignored, 5th accepted
    restart();
    frame(10'h001, 1'b0);
    repeat (4) frame(10'h002, 1'b0);
    check_eq("lock_ignored", score, 10);
    frame(10'h002, 1'b0);
    check_eq("lock_accept", score, 20);
    check_eq("lock_dir", ball_dir_y, 0);

    // brick + paddle on the same tick forces up
    restart();
    frame(10'h004, 1'b0);
    repeat (4) frame(10'h000, 1'b0);
    frame(10'h200, 1'b1);
    check_eq("bp_alive", block_alive, 10'h1FB);
    check_eq("bp_dir", ball_dir_y, 0);
    check_eq("bp_score", score, 20);

    // paddle in HOLD, paddle while up, collide between ticks
    restart();
    frame(10'h004, 1'b0);
    frame(10'h000, 1'b1);
    check_eq("pad_hold", ball_dir_y, 0);
    frame(10'h000, 1'b1);
    check_eq("pad_up", ball_dir_y, 0);
    repeat (4) frame(10'h000, 1'b0);
    @(negedge clk);
    collide_block = 10'h3FF;
    idle(3);
    collide_block = '0;
    check_eq("no_tick_alive", block_alive, 10'h3FB);

    // ball_lost leaves HOLD immediately; coincident tick discarded
    restart();
    frame(10'h001, 1'b0);
    pulse_lost();
    check_eq("lost_hold_lives", lives, 2);
    check_eq("lost_hold_dir", ball_dir_y, 0);
    frame(10'h002, 1'b0);
    check_eq("lost_hold_play", score, 20);
    @(negedge clk);
    ball_lost = 1'b1; frame_tick = 1'b1; collide_block = 10'h004;
    @(posedge clk);
    #1;
    ball_lost = 1'b0; frame_tick = 1'b0; collide_block = '0;
    check_eq("coinc_alive", block_alive, 10'h3FC);
    check_eq("coinc_lives", lives, 1);

    // lives exhaustion
    restart();
    pulse_lost();
    check_eq("lives_2", lives, 2);
    pulse_lost();
    check_eq("lives_1", lives, 1);
    check_eq("go_early", game_over, 0);
    pulse_lost();
    check_eq("lives_0", lives, 0);
    check_eq("go_set", game_over, 1);
    frame(10'h001, 1'b0);
    check_eq("over_alive", block_alive, 10'h3FF);
    check_eq("over_score", score, 0);
    pulse_lost();
    check_eq("over_lost", lives, 0);
    check_eq("go_hold", game_over, 1);

    // clear all bricks, then new game
    restart();
    check_eq("ng_go", game_over, 0);
    check_eq("ng_lives", lives, 3);
    frame(10'h1FF, 1'b0);
    check_eq("part_score", score, 90);
    check_eq("part_clear", level_clear, 0);
    repeat (4) frame(10'h000, 1'b0);
    frame(10'h200, 1'b0);
    check_eq("clr_alive", block_alive, 10'h000);
    check_eq("clr_flag", level_clear, 1);
    check_eq("clr_score", score, 100);
    pulse_lost();
    check_eq("clr_lost_ign", lives, 3);
    idle(6);
    check_eq("clr_held", level_clear, 1);
    restart();
    check_eq("ng_alive", block_alive, 10'h3FF);
    check_eq("ng_score", score, 0);
    check_eq("ng_lives2", lives, 3);
    check_eq("ng_clear", level_clear, 0);

    // async reset mid-frame
    frame(10'h008, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_eq("async_alive", block_alive, 10'h3FF);
    check_eq("async_score", score, 0);
    @(negedge clk);
    rst = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/brick_manager.md
# brick_manager

Consumes the per-cycle collision flags from the collision detector and turns them into game state: which bricks are alive, ball vertical direction, score, lives and end-of-level/end-of-game status. Sits between the collision detector and the ball-motion/renderer logic; evaluates hits once per video frame on `frame_tick`, so a multi-frame overlap costs a brick exactly once.

## Interface
- `NUM_BLOCKS`, 10: brick count. Bits 0–4 are the top row, left to right; bits 5–9 are the lower row (+24 px).
- `POINTS`, 10: score added per scoring hit.
- `LOCKOUT_FRAMES`, 4: frames during which brick hits are ignored after a brick bounce.
- `START_LIVES`, 3: lives loaded on reset and on `new_game`.
- `SCORE_W`, 16: score width.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `frame_tick`, in, 1: one-cycle pulse per frame; hit-evaluation strobe.
- `collide_block`, in, NUM_BLOCKS: level collision flags from the detector.
- `collide_paddle`, in, 1: level paddle collision flag.
- `ball_lost`, in, 1: one-cycle pulse when the ball passes the bottom edge.
- `new_game`, in, 1: one-cycle restart request.
- `block_alive`, out, NUM_BLOCKS: 1 means the brick is drawn and collidable.
- `block_cracked`, out, NUM_BLOCKS: 1 means the brick has taken one hit (see Configuration).
- `ball_dir_y`, out, 1: 0 means up (−y), 1 means down.
- `score`, out, SCORE_W: saturating score.
- `lives`, out, 3: remaining lives.
- `hit_pulse`, out, 1: one-cycle pulse on any accepted brick hit.
- `level_clear`, out, 1: all bricks destroyed.
- `game_over`, out, 1: lives exhausted.

## Operation
- FSM states and behaviour:
  - `PLAY`: hits are evaluated.
  - `HOLD`: brick hits are ignored; paddle hits and `ball_lost` are still processed.
  - `CLEAR`: waits for `new_game`; `level_clear` is 1.
  - `OVER`: waits for `new_game`; `game_over` is 1.
- Accepted hit set: `hits = collide_block & block_alive`, sampled on a cycle with `frame_tick` in `PLAY`.
- When `hits` is non-zero:
  - Every hit brick is cleared in the same cycle.
  - `score += POINTS * popcount(hits)`, saturating at all-ones.
  - `ball_dir_y` toggles.
  - `hit_pulse` is 1 for one cycle.
  - The lockout counter loads `LOCKOUT_FRAMES` and the FSM goes to `HOLD`.
- If the same update leaves `block_alive == 0`, the FSM goes to `CLEAR`, not `HOLD`.
- `HOLD` exit: the counter decrements on each `frame_tick` and the FSM returns to `PLAY` on the tick that takes it to 0. With `LOCKOUT_FRAMES = 0`, `HOLD` lasts one cycle.
- Paddle: on `frame_tick` in `PLAY` or `HOLD` with `collide_paddle` = 1 and `ball_dir_y` = 1, set `ball_dir_y` = 0. A paddle hit while already moving up causes no change.
- Brick hit and paddle hit on the same tick: bricks are cleared and scored, and `ball_dir_y` is forced to 0 (no toggle).
- `ball_lost` in `PLAY` or `HOLD`, on any cycle:
  - If `lives` > 1: `lives` decrements, `ball_dir_y` = 0, FSM goes to `PLAY`, counter is cleared.
  - If `lives` = 1: `lives` = 0 and FSM goes to `OVER`.
  - `ball_lost` is ignored in `CLEAR` and `OVER`.
- Priority, highest first: reset, then `new_game`, then `ball_lost`, then `frame_tick` evaluation. A `frame_tick` that coincides with `ball_lost` is discarded.
- `new_game` from any state reloads everything to its reset values.
- Reset values:
  - `block_alive` all 1s; `block_cracked` all 0s; `ball_dir_y` 0; `score` 0; `lives` START_LIVES.
  - `hit_pulse`, `level_clear` and `game_over` all 0.
  - FSM in `PLAY`, counter 0.

## Timing
- All outputs are registered. The effect of a `frame_tick` sampled at edge N is visible after edge N.
- `collide_*` inputs are sampled on the `frame_tick` cycle only. They are ignored between ticks.
- `hit_pulse` is exactly one cycle wide.
- `level_clear` and `game_over` are levels, held until `new_game`.
- Reset assertion mid-frame takes effect immediately (asynchronous). Deassertion is expected to be synchronized upstream.

## Configuration
- `BRICK_MANAGER_TWO_HIT_EN` defined: top-row bricks (bits 0–4) need two hits.
  - First accepted hit: sets `block_cracked`, keeps `block_alive`, scores POINTS, bounces and enters `HOLD`.
  - Second accepted hit: clears both bits and scores POINTS.
  - Lower-row bricks are unchanged (single hit).
- Undefined: every brick clears on its first hit, and `block_cracked` is constant 0.

## Structure
- Package `brick_pkg` holds:
  - the FSM state enum `brick_state_t`;
  - `TOP_ROW_MASK` (10'h01F) and `BOTTOM_ROW_MASK` (10'h3E0);
  - the lives width constant.
- One sub-module, `brick_popcount`: combinational NUM_BLOCKS-bit population count feeding the score multiply-add.

## Test plan
- Reset, then `collide_block` = 10'h004 with one `frame_tick` → `block_alive` = 10'h3FB, `score` = 10, `ball_dir_y` 0→1, `hit_pulse` for 1 cycle.
- `collide_block` = 10'h021 held for 6 ticks → bricks cleared once, `score` = 20; no further toggle during the 4 `HOLD` ticks.
- `ball_dir_y` = 1 with `collide_paddle` and `collide_block` = 10'h200 on the same tick → brick 9 cleared and `ball_dir_y` = 0.
- `ball_lost` three times from reset → `lives` goes 2, then 1, then 0; `game_over` = 1; a later `collide_block` has no effect.
- Clear all 10 bricks → `level_clear` = 1, state `CLEAR`. `new_game` → `block_alive` = 10'h3FF, `score` = 0, `lives` = 3.
- With `BRICK_MANAGER_TWO_HIT_EN`, hit bit 0 twice (separated by more than 4 ticks) → `block_cracked[0]` rises and then clears, `block_alive[0]` = 0, `score` = 20.
